logicnets_layer_sequencer: RTL and testbench

Time-multiplexed evaluator for one LogicNets layer. A single shared 6-input, 1-output truth-table neuron is evaluated once per output neuron. The block latches an input activation vector, walks the neuron index 0..NEURONS-1, and gathers each neuron's fan-in bits through an external connectivity table. It collects the 1-bit results into an output vector and hands that vector downstream over a valid/ready handshake. It sits between two layer stages and replaces NEURONS parallel LUT instances with one shared LUT plus a neuron-select.

---
 rtl/logicnets_layer_sequencer.sv | 138 +++++++++++++
 tb/tb_logicnets_layer_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logicnets_layer_sequencer.sv
// Time-multiplexed LogicNets layer: one shared 6-input LUT walked over all neurons.
// Optional LOGICNETS_SEQ_LUT_PIPE_EN registers lut_out ahead of the capture.
module logicnets_layer_sequencer #(
  parameter int IN_BITS = 64,
  parameter int NEURONS = 64,
  parameter int FANIN   = 6,
  parameter int IW      = $clog2(IN_BITS),
  parameter int NW      = $clog2(NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_BITS-1:0]    in_data,
  output logic [NW-1:0]         neuron_sel,
  input  logic [FANIN*IW-1:0]   conn_idx,
  output logic [FANIN-1:0]      lut_addr,
  input  logic                  lut_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NEURONS-1:0]    out_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  localparam logic [NW-1:0] LAST = NW'(NEURONS - 1);

  state_t             state;
  logic [IN_BITS-1:0] in_reg;
  logic [NEURONS-1:0] res;
  logic [NEURONS-1:0] res_nxt;
  logic [IN_BITS-1:0] sh;
  logic               gather;
  logic               cap_bit;

  assign in_ready = (state == IDLE);
  assign busy     = (state == EVAL);

`ifdef LOGICNETS_SEQ_LUT_PIPE_EN
  logic          lut_q;
  logic          cap_vld;
  logic          drain;
  logic [NW-1:0] cap_sel;

  // The drain cycle only retires the last registered LUT result.
  assign gather  = busy & ~drain;
  assign cap_bit = lut_q;
`else
  logic [NW-1:0] cap_sel;

  assign gather  = busy;
  assign cap_bit = lut_out;
  assign cap_sel = neuron_sel;
`endif

  // A logical shift past the vector end yields 0, so out-of-range indices read as 0.
  always_comb begin
    lut_addr = '0;
    sh       = '0;
    for (int k = 0; k < FANIN; k++) begin
      sh          = in_reg >> conn_idx[k*IW +: IW];
      lut_addr[k] = gather & sh[0];
    end
  end

  always_comb begin
    res_nxt          = res;
    res_nxt[cap_sel] = cap_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_reg     <= '0;
      res        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      neuron_sel <= '0;
`ifdef LOGICNETS_SEQ_LUT_PIPE_EN
      lut_q      <= 1'b0;
      cap_vld    <= 1'b0;
      drain      <= 1'b0;
      cap_sel    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg     <= in_data;
            neuron_sel <= '0;
            state      <= EVAL;
`ifdef LOGICNETS_SEQ_LUT_PIPE_EN
            cap_vld    <= 1'b0;
            drain      <= 1'b0;
`endif
          end
        end
        EVAL: begin
`ifdef LOGICNETS_SEQ_LUT_PIPE_EN
          lut_q   <= lut_out;
          cap_sel <= neuron_sel;
          cap_vld <= ~drain;
          if (cap_vld)
            res <= res_nxt;
          if (drain) begin
            out_data  <= res_nxt;
            out_valid <= 1'b1;
            drain     <= 1'b0;
            state     <= HOLD;
          end else if (neuron_sel == LAST) begin
            drain <= 1'b1;
          end else begin
            neuron_sel <= neuron_sel + 1'b1;
          end
`else
          res <= res_nxt;
          if (neuron_sel == LAST) begin
            out_data  <= res_nxt;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            neuron_sel <= neuron_sel + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logicnets_layer_sequencer.sv
// Bench for logicnets_layer_sequencer: vector table, scoreboard and
// hand-written back-pressure, streaming and mid-EVAL reset sequences.
module tb_logicnets_layer_sequencer;

  localparam int IN_BITS = 8;
  localparam int NEURONS = 4;
  localparam int FANIN   = 6;
  localparam int IW      = 4;
  localparam int NW      = 2;
`ifdef LOGICNETS_SEQ_LUT_PIPE_EN
  localparam int LAT = NEURONS + 2;
`else
  localparam int LAT = NEURONS + 1;
`endif
  localparam int PERIOD = LAT + 1;
  localparam int TMO    = 200;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_data = '0;
  logic [NW-1:0]       neuron_sel;
  logic [FANIN*IW-1:0] conn_idx;
  logic [FANIN-1:0]    lut_addr;
  logic                lut_out;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [NEURONS-1:0]  out_data;
  logic                busy;

  logic ovr  = 1'b0;
  logic seqm = 1'b0;

  logicnets_layer_sequencer #(
    .IN_BITS(IN_BITS), .NEURONS(NEURONS), .FANIN(FANIN), .IW(IW), .NW(NW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .neuron_sel(neuron_sel), .conn_idx(conn_idx),
    .lut_addr(lut_addr), .lut_out(lut_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Connectivity table: neuron n reads {n..n+5} mod 8, optional bad index.
  always_comb begin
    conn_idx = '0;
    for (int k = 0; k < FANIN; k++)
      conn_idx[k*IW +: IW] = (ovr && neuron_sel == 2'd2 && k == 3)
        ? IW'(IN_BITS + 1)
        : IW'((int'(neuron_sel) + k) % IN_BITS);
  end

  assign lut_out = seqm ? (neuron_sel == NW'(NEURONS - 1)) : ^lut_addr;

  function automatic logic [FANIN-1:0] addr_of(
    input logic [IN_BITS-1:0] v, input int n, input logic o);
    logic [FANIN-1:0] a;
    for (int k = 0; k < FANIN; k++)
      a[k] = (o && n == 2 && k == 3) ? 1'b0 : v[(n + k) % IN_BITS];
    return a;
  endfunction

  function automatic logic [NEURONS-1:0] ref_vec(
    input logic [IN_BITS-1:0] v, input logic o, input logic s);
    logic [NEURONS-1:0] r;
    for (int n = 0; n < NEURONS; n++)
      r[n] = s ? (n == NEURONS - 1) : ^addr_of(v, n, o);
    return r;
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout or unexpected event", nm);
  endtask

  typedef struct {
    logic [NEURONS-1:0] data;
    int                 cyc;
  } sb_t;

  sb_t                sb[$];
  int                 cyc      = 0;
  int                 acc_cnt  = 0;
  int                 last_acc = 0;
  int                 last_hs  = 0;
  int                 s_cnt    = 0;
  int                 exp_sel  = NEURONS;
  logic               stream   = 1'b0;
  logic               ov_prev  = 1'b0;
  logic [NEURONS-1:0] hold_d   = '0;
  logic [NEURONS-1:0] cur_exp  = '0;
  logic [IN_BITS-1:0] cur_in   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
      exp_sel = NEURONS;
      sb.delete();
    end else begin
      if (busy && exp_sel < NEURONS) begin
        chk("sel", 32'(neuron_sel), 32'(exp_sel));
        chk("addr", 32'(lut_addr), 32'(addr_of(cur_in, exp_sel, ovr)));
        exp_sel++;
      end
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) fail("spurious_out");
        else chk("latency", 32'(cyc - sb[0].cyc), 32'(LAT));
        hold_d = out_data;
      end
      if (out_valid && ov_prev) begin
        chk("hold_stable", 32'(out_data), 32'(hold_d));
        chk("hold_inrdy", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail("sb_empty");
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("data", 32'(out_data), 32'(e.data));
        end
        last_hs = cyc;
      end
      if (in_valid && in_ready) begin
        if (stream) begin
          if (s_cnt > 0) chk("period", 32'(cyc - last_acc), 32'(PERIOD));
          s_cnt++;
        end else begin
          s_cnt = 0;
        end
        sb.push_back('{data: cur_exp, cyc: cyc});
        cur_in   = in_data;
        exp_sel  = 0;
        last_acc = cyc;
        acc_cnt++;
      end
      ov_prev = out_valid;
    end
  end

  task automatic wait_acc(input int n0, input string nm);
    int i;
    for (i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (acc_cnt != n0) break;
    end
    if (i == TMO) fail(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_BITS-1:0] v, input logic o,
                      input logic s, input logic [NEURONS-1:0] e);
    int n0;
    n0       = acc_cnt;
    ovr      = o;
    seqm     = s;
    cur_exp  = e;
    in_data  = v;
    in_valid = 1'b1;
    wait_acc(n0, "accept");
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready) break;
    end
    if (i == TMO) fail(nm);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [IN_BITS-1:0] din;
    logic               o;
    logic               s;
    logic [NEURONS-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n0;
    int i;
    logic [IN_BITS-1:0] r;

    tbl[0] = '{din: 8'b1011_0010, o: 1'b0, s: 1'b0, exp: 4'b1111};
    tbl[1] = '{din: 8'h00,        o: 1'b0, s: 1'b0, exp: 4'b0000};
    tbl[2] = '{din: 8'hFF,        o: 1'b0, s: 1'b0, exp: 4'b0000};
    tbl[3] = '{din: 8'h5A,        o: 1'b0, s: 1'b0, exp: 4'b1101};
    tbl[4] = '{din: 8'b1011_0010, o: 1'b1, s: 1'b0, exp: 4'b1011};
    tbl[5] = '{din: 8'h37,        o: 1'b0, s: 1'b1, exp: 4'b1000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(neuron_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(lut_addr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int t = 0; t < 6; t++) begin
      send(tbl[t].din, tbl[t].o, tbl[t].s, tbl[t].exp);
      wait_done("vec_done");
    end

    // Back-pressure: hold the result while a new vector waits.
    out_ready = 1'b0;
    send(8'h5A, 1'b0, 1'b0, 4'b1101);
    for (i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (i == TMO) fail("bp_out_valid");
    @(posedge clk);
    #1;
    n0       = acc_cnt;
    in_data  = 8'h33;
    cur_exp  = ref_vec(8'h33, 1'b0, 1'b0);
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_no_accept", 32'(acc_cnt), 32'(n0));
    out_ready = 1'b1;
    wait_acc(n0, "bp_accept");
    in_valid = 1'b0;
    chk("bp_gap", 32'(last_acc - last_hs), 32'd1);
    wait_done("bp_done");

    // Streaming: in_valid and out_ready held high for 8 vectors.
    stream   = 1'b1;
    in_valid = 1'b1;
    for (int v = 0; v < 8; v++) begin
      r       = 8'($urandom);
      n0      = acc_cnt;
      in_data = r;
      cur_exp = ref_vec(r, 1'b0, 1'b0);
      wait_acc(n0, "stream_accept");
    end
    in_valid = 1'b0;
    wait_done("stream_done");
    stream = 1'b0;
    chk("stream_count", 32'(s_cnt), 32'd8);

    // Reset in the middle of EVAL, then a clean re-run.
    send(8'hC6, 1'b0, 1'b0, ref_vec(8'hC6, 1'b0, 1'b0));
    for (i = 0; i < TMO; i++) begin
      if (busy && neuron_sel == 2'd2) break;
      @(posedge clk);
      #1;
    end
    if (i == TMO) fail("mid_eval_wait");
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'hC6, 1'b0, 1'b0, ref_vec(8'hC6, 1'b0, 1'b0));
    wait_done("post_rst_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
